// File: rtl/vital_pkg.sv
// ============================================================================
// Module   : vital_pkg
// Purpose  : Shared types and constants for the vital-sign scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vital_pkg;

    localparam int SAMPLE_W = 8;
    localparam int TMR_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_EVAL = 2'd3
    } state_t;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;

endpackage

`default_nettype wire

// File: rtl/vital_scan_timer.sv
// ============================================================================
// Module   : vital_scan_timer
// Purpose  : Loadable down-counter shared by the scan interval and ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vital_scan_timer
    import vital_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             done_o
);

    logic [TMR_W-1:0] cnt_q;

    // Loading N makes done_o rise in the (N+1)-th cycle after the load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/vital_scan_ctrl.sv
// ============================================================================
// Module   : vital_scan_ctrl
// Purpose  : Round-robin vital-sign sampler with threshold check, dose output
//            and sticky emergency flag. Define VITAL_TIMEOUT_EN for ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vital_scan_ctrl
    import vital_pkg::*;
#(
    parameter int SCAN_DIV    = 100,
    parameter int EMERG_CNT   = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                sens_req,
    output logic [1:0]          sens_sel,
    input  logic                sens_ack,
    input  logic [SAMPLE_W-1:0] sens_data,
    input  logic [SAMPLE_W-1:0] thr_f1,
    input  logic [SAMPLE_W-1:0] thr_f2,
    input  logic [SAMPLE_W-1:0] thr_f3,
    input  logic [SAMPLE_W-1:0] thr_f4,
    output logic [SAMPLE_W-1:0] d_out,
    output logic                e_out,
    input  logic                emerg_clr,
    output logic                sens_fault,
    output logic                scan_done
);

    localparam logic [TMR_W-1:0] C_DIV_LD  = TMR_W'(SCAN_DIV - 1);
    localparam logic [TMR_W-1:0] C_ACK_LD  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]       C_EMERG   = 4'(EMERG_CNT);

    state_t              state_q, state_d;
    logic [1:0]          chan_q, chan_d;
    logic                gap_q, gap_d;
    logic [SAMPLE_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [SAMPLE_W-1:0] dose_q, dose_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                emerg_q, emerg_d;
    logic                done_q, done_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_done;
    logic                w_req_active;
    logic                w_timeout;
    logic                w_viol;
    logic [3:0]          w_cnt_inc;
    logic [SAMPLE_W-1:0] w_dose;

    vital_scan_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // gap_q marks the mandatory request-low cycle between channels.
    assign w_req_active = (state_q == ST_REQ) && !gap_q;

`ifdef VITAL_TIMEOUT_EN
    logic fault_q;
    assign w_timeout = w_req_active && tmr_done && !sens_ack;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (w_timeout) begin
            fault_q <= 1'b1;
        end
    end
    assign sens_fault = fault_q;
`else
    assign w_timeout  = 1'b0;
    assign sens_fault = 1'b0;
`endif

    assign w_viol    = (a_q < thr_f1) || (a_q > thr_f2) || (b_q < thr_f3) || (c_q > thr_f4);
    assign w_cnt_inc = (cnt_q >= C_EMERG) ? C_EMERG : cnt_q + 4'd1;
    assign w_dose    = (b_q < thr_f3) ? (thr_f3 - b_q) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            chan_q  <= CH_A;
            gap_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            dose_q  <= '0;
            cnt_q   <= '0;
            emerg_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            gap_q   <= gap_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            dose_q  <= dose_d;
            cnt_q   <= cnt_d;
            emerg_q <= emerg_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        gap_d    = gap_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        dose_d   = dose_q;
        cnt_d    = cnt_q;
        emerg_d  = emerg_q && !emerg_clr;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = C_DIV_LD;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    state_d  = ST_REQ;
                    chan_d   = CH_A;
                    gap_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = C_ACK_LD;
                end
            end
            ST_REQ: begin
                if (gap_q) begin
                    gap_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = C_ACK_LD;
                end else if (sens_ack || w_timeout) begin
                    if (sens_ack) begin
                        case (chan_q)
                            CH_A:    a_d = sens_data;
                            CH_B:    b_d = sens_data;
                            default: c_d = sens_data;
                        endcase
                    end
                    if (chan_q == CH_C) begin
                        state_d = ST_EVAL;
                        chan_d  = CH_A;
                    end else begin
                        chan_d = chan_q + 2'd1;
                        gap_d  = 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                done_d = 1'b1;
                dose_d = w_dose;
                if (w_viol) begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == C_EMERG) begin
                        emerg_d = 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
                if (en) begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sens_req  = w_req_active;
    assign sens_sel  = chan_q;
    assign d_out     = dose_q;
    assign e_out     = emerg_q;
    assign scan_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vital_scan_ctrl.sv
// ============================================================================
// Module   : tb_vital_scan_ctrl
// Purpose  : Directed table-driven bench for vital_scan_ctrl (VITAL_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vital_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sens_ack = 1'b0;
    logic       emerg_clr = 1'b0;
    logic [7:0] sens_data = 8'h00;
    logic [7:0] thr_f1 = 8'h37;
    logic [7:0] thr_f2 = 8'h72;
    logic [7:0] thr_f3 = 8'h95;
    logic [7:0] thr_f4 = 8'h18;
    logic       sens_req;
    logic [1:0] sens_sel;
    logic [7:0] d_out;
    logic       e_out;
    logic       sens_fault;
    logic       scan_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        int         clr;   // 0 none, 1 during channel A, 2 in the EVAL cycle
        logic [7:0] d;
        logic       e;
    } vec_t;

    vec_t tv[17];

    always #5 clk = ~clk;

    vital_scan_ctrl #(
        .SCAN_DIV    (4),
        .EMERG_CNT   (3),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sens_req   (sens_req),
        .sens_sel   (sens_sel),
        .sens_ack   (sens_ack),
        .sens_data  (sens_data),
        .thr_f1     (thr_f1),
        .thr_f2     (thr_f2),
        .thr_f3     (thr_f3),
        .thr_f4     (thr_f4),
        .d_out      (d_out),
        .e_out      (e_out),
        .emerg_clr  (emerg_clr),
        .sens_fault (sens_fault),
        .scan_done  (scan_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (sens_req !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (sens_req !== 1'b1) check({name, " req wait"}, 32'(sens_req), 32'd1);
    endtask

    task automatic req_latency(input string name, input int exp);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sens_req !== 1'b1 && k < 60);
        check(name, 32'(k), 32'(exp));
    endtask

    task automatic serve_ch(input string tag, input logic [1:0] ch, input logic [7:0] data, input bit clr);
        wait_req(tag);
        check({tag, " sel"}, 32'(sens_sel), 32'(ch));
        if (clr) emerg_clr = 1'b1;
        @(negedge clk);
        emerg_clr = 1'b0;
        check({tag, " req hold"}, 32'({sens_req, sens_sel}), 32'({1'b1, ch}));
        @(negedge clk);
        sens_ack  = 1'b1;
        sens_data = data;
        @(negedge clk);
        sens_ack  = 1'b0;
        sens_data = 8'hEE;
        check({tag, " req drop"}, 32'(sens_req), 32'd0);
    endtask

    task automatic finish_scan(input string tag, input int clr, input logic [7:0] d, input logic e);
        if (clr == 2) emerg_clr = 1'b1;
        check({tag, " done early"}, 32'(scan_done), 32'd0);
        @(negedge clk);
        emerg_clr = 1'b0;
        check({tag, " done"}, 32'(scan_done), 32'd1);
        check({tag, " d_out"}, 32'(d_out), 32'(d));
        check({tag, " e_out"}, 32'(e_out), 32'(e));
        @(negedge clk);
        check({tag, " done pulse"}, 32'(scan_done), 32'd0);
    endtask

    task automatic do_scan(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input int clr, input logic [7:0] d, input logic e);
        serve_ch({tag, " A"}, 2'd0, a, clr == 1);
        serve_ch({tag, " B"}, 2'd1, b, 1'b0);
        serve_ch({tag, " C"}, 2'd2, c, 1'b0);
        finish_scan(tag, clr, d, e);
    endtask

    initial begin
        bit seen;

        tv[0]  = '{8'h50, 8'hA0, 8'h10, 0, 8'h00, 1'b0};
        tv[1]  = '{8'h50, 8'hA0, 8'h10, 0, 8'h00, 1'b0};
        tv[2]  = '{8'h50, 8'h90, 8'h10, 0, 8'h05, 1'b0};
        tv[3]  = '{8'h50, 8'h90, 8'h10, 0, 8'h05, 1'b0};
        tv[4]  = '{8'h50, 8'h90, 8'h10, 0, 8'h05, 1'b1};
        tv[5]  = '{8'h50, 8'hA0, 8'h10, 1, 8'h00, 1'b0};
        tv[6]  = '{8'h30, 8'hA0, 8'h10, 0, 8'h00, 1'b0};
        tv[7]  = '{8'h50, 8'hA0, 8'h10, 0, 8'h00, 1'b0};
        tv[8]  = '{8'h50, 8'hA0, 8'h20, 0, 8'h00, 1'b0};
        tv[9]  = '{8'h80, 8'hA0, 8'h10, 0, 8'h00, 1'b0};
        tv[10] = '{8'h50, 8'h10, 8'h10, 0, 8'h85, 1'b1};
        tv[11] = '{8'h50, 8'hA0, 8'h10, 1, 8'h00, 1'b0};
        tv[12] = '{8'h50, 8'h94, 8'h10, 0, 8'h01, 1'b0};
        tv[13] = '{8'h50, 8'h00, 8'h10, 0, 8'h95, 1'b0};
        tv[14] = '{8'h36, 8'hA0, 8'h10, 2, 8'h00, 1'b1};
        tv[15] = '{8'h37, 8'h95, 8'h18, 0, 8'h00, 1'b1};
        tv[16] = '{8'h72, 8'hFF, 8'h00, 1, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        check("rst sens_req", 32'(sens_req), 32'd0);
        check("rst sens_sel", 32'(sens_sel), 32'd0);
        check("rst d_out", 32'(d_out), 32'd0);
        check("rst e_out", 32'(e_out), 32'd0);
        check("rst sens_fault", 32'(sens_fault), 32'd0);
        check("rst scan_done", 32'(scan_done), 32'd0);

        rst_n = 1'b1;
        en    = 1'b1;
        req_latency("first scan latency", 5);

        for (int i = 0; i < 17; i++) begin
            do_scan($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].c, tv[i].clr, tv[i].d, tv[i].e);
        end

        // en low while waiting: must fall back to IDLE and restart the full interval
        en = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sens_req) seen = 1'b1;
        end
        check("en low in WAIT no req", 32'(seen), 32'd0);
        en = 1'b1;
        req_latency("restart after WAIT abort", 5);

        // en low mid-scan: scan completes, then controller idles
        wait_req("en drop");
        en = 1'b0;
        do_scan("en drop scan", 8'h50, 8'hA0, 8'h10, 0, 8'h00, 1'b0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sens_req) seen = 1'b1;
        end
        check("idle after en drop", 32'(seen), 32'd0);
        en = 1'b1;
        req_latency("restart after en drop", 5);

        do_scan("pre timeout", 8'h50, 8'h90, 8'h10, 0, 8'h05, 1'b0);

`ifdef VITAL_TIMEOUT_EN
        serve_ch("to A", 2'd0, 8'h50, 1'b0);
        wait_req("to B");
        check("to B sel", 32'(sens_sel), 32'd1);
        repeat (14) @(negedge clk);
        check("to fault before limit", 32'(sens_fault), 32'd0);
        check("to req before limit", 32'(sens_req), 32'd1);
        @(negedge clk);
        check("to fault set", 32'(sens_fault), 32'd1);
        check("to req drop", 32'(sens_req), 32'd0);
        serve_ch("to C", 2'd2, 8'h10, 1'b0);
        finish_scan("to scan", 0, 8'h05, 1'b0);
`endif

        // reset while a request is outstanding
        wait_req("rst mid");
        rst_n = 1'b0;
        @(negedge clk);
        check("mid rst sens_req", 32'(sens_req), 32'd0);
        check("mid rst sens_sel", 32'(sens_sel), 32'd0);
        check("mid rst d_out", 32'(d_out), 32'd0);
        check("mid rst e_out", 32'(e_out), 32'd0);
        check("mid rst sens_fault", 32'(sens_fault), 32'd0);
        check("mid rst scan_done", 32'(scan_done), 32'd0);
        rst_n = 1'b1;
        req_latency("restart after reset", 5);
        do_scan("post rst", 8'h50, 8'h90, 8'h10, 0, 8'h05, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
